// File: rtl/nb_adc_decimator.sv
// nb_adc_decimator: I/Q boxcar decimator between the ADC pads and the NB DSP core.
// Sums 2^D signed samples and emits their floor mean on a valid/ready port.
// Output samples are framed into FRAME_LEN-sample blocks for the FFT/correlator.
// Ports:
//   CLK, RESETn          clock, synchronous active-low reset
//   EN                   run enable (START_FFT); low returns the block to IDLE
//   ADC_I, ADC_Q         signed DW-bit samples, valid every cycle
//   DECIMATE_FACTOR      exponent D, latched on IDLE->RUN
//   OUT_I, OUT_Q         decimated samples
//   OUT_VALID/OUT_READY  output handshake
//   OUT_LAST             qualifies the final sample of a frame
//   SAMPLE_IDX           frame position of the presented sample
//   FRAME_DONE           high while in DONE
//   OVERRUN              sticky, set when a result is dropped
module nb_adc_decimator #(
    parameter int unsigned DW         = 10,
    parameter int unsigned DMAX       = 7,
    parameter int unsigned FRAME_LEN  = 12,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          EN,
    input  logic [DW-1:0] ADC_I,
    input  logic [DW-1:0] ADC_Q,
    input  logic [2:0]    DECIMATE_FACTOR,
    output logic [DW-1:0] OUT_I,
    output logic [DW-1:0] OUT_Q,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          OUT_LAST,
    output logic [3:0]    SAMPLE_IDX,
    output logic          FRAME_DONE,
    output logic          OVERRUN
);
    localparam int unsigned AW  = DW + DMAX;
    localparam int unsigned PW  = DMAX;
    localparam int unsigned CW  = 4;
    localparam int unsigned DFW = 3;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [DFW-1:0]       d_q, d_d;
    logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        out_i_q, out_i_d, out_q_q, out_q_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;

    logic [PW:0]          ratio_c;
    logic [PW-1:0]        phase_max_c;
    logic signed [AW-1:0] sum_i_c, sum_q_c, mean_i_c, mean_q_c;
    logic                 produce_c;

    // Next-state, accumulation, framing and handshake
    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        out_i_d      = out_i_q;
        out_q_d      = out_q_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        idx_d        = idx_q;
        overrun_d    = overrun_q;
        produce_c    = 1'b0;

        ratio_c     = (PW+1)'(1) << d_q;
        phase_max_c = PW'(ratio_c - (PW+1)'(1));
        // The current sample joins the sum in the same cycle the mean is taken
        sum_i_c     = acc_i_q + AW'($signed(ADC_I));
        sum_q_c     = acc_q_q + AW'($signed(ADC_Q));
        mean_i_c    = sum_i_c >>> d_q;
        mean_q_c    = sum_q_c >>> d_q;

        if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (!EN) begin
            // Dropping EN discards any partial sum; OUT_I/OUT_Q keep their last value
            state_d     = ST_IDLE;
            acc_i_d     = '0;
            acc_q_d     = '0;
            phase_d     = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    d_d     = DECIMATE_FACTOR;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    phase_d = '0;
                    cnt_d   = '0;
                end
                ST_RUN: begin
                    if (phase_q == phase_max_c) begin
                        produce_c = 1'b1;
                        acc_i_d   = '0;
                        acc_q_d   = '0;
                        phase_d   = '0;
                        if (cnt_q == LAST_IDX) begin
                            cnt_d = '0;
                            if (!CONTINUOUS) state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        acc_i_d = sum_i_c;
                        acc_q_d = sum_q_c;
                        phase_d = phase_q + PW'(1);
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end

        // A result finding the output slot still occupied is lost but still counted
        if (produce_c) begin
            if (!out_valid_q || OUT_READY) begin
                out_i_d     = DW'(mean_i_c);
                out_q_d     = DW'(mean_q_c);
                out_valid_d = 1'b1;
                out_last_d  = (cnt_q == LAST_IDX);
                idx_d       = cnt_q;
            end else begin
                overrun_d = 1'b1;
            end
        end

        frame_done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q      <= ST_IDLE;
            d_q          <= '0;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            phase_q      <= '0;
            cnt_q        <= '0;
            out_i_q      <= '0;
            out_q_q      <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            out_i_q      <= out_i_d;
            out_q_q      <= out_q_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign OUT_I      = out_i_q;
    assign OUT_Q      = out_q_q;
    assign OUT_VALID  = out_valid_q;
    assign OUT_LAST   = out_last_q;
    assign SAMPLE_IDX = idx_q;
    assign FRAME_DONE = frame_done_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_nb_adc_decimator.sv
// Testbench for nb_adc_decimator: random I/Q streams checked against floor-mean
// group averages, plus framing, backpressure, EN-drop and reset scenarios.
module tb_nb_adc_decimator;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] adc_i, adc_q;
    logic [2:0] dfac;
    logic       rdy;

    logic [9:0] o_i, o_q, c_i, c_q;
    logic       o_v, o_last, o_fd, o_ov, c_v, c_last, c_fd, c_ov;
    logic [3:0] o_idx, c_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int pat_i[$];
    int pat_q[$];

    nb_adc_decimator #(.DW(10), .DMAX(7), .FRAME_LEN(12), .CONTINUOUS(1'b0)) dut (
        .CLK(clk), .RESETn(rst_n), .EN(en), .ADC_I(adc_i), .ADC_Q(adc_q),
        .DECIMATE_FACTOR(dfac), .OUT_I(o_i), .OUT_Q(o_q), .OUT_VALID(o_v),
        .OUT_READY(rdy), .OUT_LAST(o_last), .SAMPLE_IDX(o_idx),
        .FRAME_DONE(o_fd), .OVERRUN(o_ov)
    );

    nb_adc_decimator #(.DW(10), .DMAX(7), .FRAME_LEN(12), .CONTINUOUS(1'b1)) dut_c (
        .CLK(clk), .RESETn(rst_n), .EN(en), .ADC_I(adc_i), .ADC_Q(adc_q),
        .DECIMATE_FACTOR(dfac), .OUT_I(c_i), .OUT_Q(c_q), .OUT_VALID(c_v),
        .OUT_READY(rdy), .OUT_LAST(c_last), .SAMPLE_IDX(c_idx),
        .FRAME_DONE(c_fd), .OVERRUN(c_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input int i, input int q, input bit r);
        en    = e;
        adc_i = 10'(i);
        adc_q = 10'(q);
        rdy   = r;
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(1023)) - 512;
    endfunction

    // Mean of a group rounded toward minus infinity
    function automatic int floor_mean(input int s, input int r);
        int m;
        m = s / r;
        if (s < 0 && (s % r) != 0) m = m - 1;
        return m;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 1'b1);
        dfac = 3'd0;
        tick();
        tick();
        n_checks++; if (o_i !== 10'd0) $display("FAIL reset_out_i got %h exp 0", o_i); else n_pass++;
        n_checks++; if (o_q !== 10'd0) $display("FAIL reset_out_q got %h exp 0", o_q); else n_pass++;
        n_checks++; if (o_v !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_v); else n_pass++;
        n_checks++; if (o_last !== 1'b0) $display("FAIL reset_last got %b exp 0", o_last); else n_pass++;
        n_checks++; if (o_idx !== 4'd0) $display("FAIL reset_idx got %0d exp 0", o_idx); else n_pass++;
        n_checks++; if (o_fd !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", o_fd); else n_pass++;
        n_checks++; if (o_ov !== 1'b0) $display("FAIL reset_overrun got %b exp 0", o_ov); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    // Feeds pat_i/pat_q with READY=1 and checks every cycle against group means
    task automatic run_stream(input int d, input int d_mid, input int hold, input string name);
        int r, n, ng, s_i, s_q;
        int exp_i[$];
        int exp_q[$];
        r  = 1 << d;
        n  = pat_i.size();
        ng = n / r;
        for (int g = 0; g < ng; g++) begin
            s_i = 0;
            s_q = 0;
            for (int k = 0; k < r; k++) begin
                s_i += pat_i[g*r + k];
                s_q += pat_q[g*r + k];
            end
            exp_i.push_back(floor_mean(s_i, r));
            exp_q.push_back(floor_mean(s_q, r));
        end
        dfac = 3'(d);
        drive(1'b1, 300, -300, 1'b1);
        tick();
        n_checks++;
        if (o_v !== 1'b0) $display("FAIL %s entry_valid got %b exp 0", name, o_v); else n_pass++;
        dfac = 3'(d_mid);
        for (int k = 0; k < n; k++) begin
            bit ev;
            int g;
            drive(1'b1, pat_i[k], pat_q[k], 1'b1);
            tick();
            ev = ((k + 1) % r) == 0;
            g  = k / r;
            n_checks++;
            if (o_v !== ev) $display("FAIL %s valid k=%0d got %b exp %b", name, k, o_v, ev); else n_pass++;
            if (ev) begin
                n_checks++;
                if ({o_i, o_q, o_idx, o_last} !== {10'(exp_i[g]), 10'(exp_q[g]), 4'(g), (g == 11)})
                    $display("FAIL %s sample g=%0d got i=%0d q=%0d idx=%0d last=%b exp i=%0d q=%0d idx=%0d last=%b",
                             name, g, $signed(o_i), $signed(o_q), o_idx, o_last,
                             exp_i[g], exp_q[g], g, (g == 11));
                else n_pass++;
            end
            n_checks++;
            if (o_fd !== (k + 1 >= 12 * r)) $display("FAIL %s frame_done k=%0d got %b", name, k, o_fd); else n_pass++;
        end
        for (int h = 0; h < hold; h++) begin
            drive(1'b1, rnd_s(), rnd_s(), 1'b1);
            tick();
            n_checks++;
            if ({o_v, o_fd} !== {1'b0, (ng >= 12)})
                $display("FAIL %s hold h=%0d got v=%b fd=%b exp v=0 fd=%b", name, h, o_v, o_fd, (ng >= 12));
            else n_pass++;
        end
        drive(1'b0, 0, 0, 1'b1);
        tick();
        n_checks++;
        if ({o_v, o_fd, o_ov} !== 3'b000) $display("FAIL %s en_low got v/fd/ov=%b exp 000", name, {o_v, o_fd, o_ov});
        else n_pass++;
    endtask

    task automatic test_basic_d2();
        pat_i.delete(); pat_q.delete();
        for (int k = 0; k < 16; k++) begin
            pat_i.push_back((k % 4) + 1);
            pat_q.push_back(-3);
        end
        run_stream(2, 0, 0, "basic_d2");
    endtask

    task automatic test_floor_and_limits();
        int v[12] = '{-1, 0, 0, 0, 511, 511, 511, 511, -512, -512, -512, -512};
        pat_i.delete(); pat_q.delete();
        for (int k = 0; k < 12; k++) begin
            pat_i.push_back(v[k]);
            pat_q.push_back(rnd_s());
        end
        for (int k = 0; k < 20; k++) begin
            pat_i.push_back(rnd_s());
            pat_q.push_back(rnd_s());
        end
        run_stream(2, 7, 0, "floor_d2");
    endtask

    task automatic test_random_ratios();
        int ds[4] = '{1, 3, 5, 7};
        int gs[4] = '{6, 4, 3, 1};
        for (int t = 0; t < 4; t++) begin
            pat_i.delete(); pat_q.delete();
            for (int k = 0; k < gs[t] * (1 << ds[t]); k++) begin
                pat_i.push_back(t == 3 ? -512 + int'($urandom_range(3)) : rnd_s());
                pat_q.push_back(rnd_s());
            end
            run_stream(ds[t], (ds[t] + 1 + int'($urandom_range(5))) % 8, 0, $sformatf("rand_d%0d", ds[t]));
        end
    endtask

    task automatic test_d0_frame();
        pat_i.delete(); pat_q.delete();
        for (int k = 0; k < 12; k++) begin
            pat_i.push_back(k);
            pat_q.push_back(rnd_s());
        end
        run_stream(0, 5, 6, "d0_frame");
    endtask

    task automatic test_overrun();
        int mi[6];
        int r_i[12];
        bit ev[10]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        int eg[10]  = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 4};
        for (int k = 0; k < 12; k++) r_i[k] = rnd_s();
        for (int g = 0; g < 6; g++) mi[g] = floor_mean(r_i[2*g] + r_i[2*g + 1], 2);
        dfac = 3'd1;
        drive(1'b1, 0, 0, 1'b1);
        tick();
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, r_i[j], 0, !(j >= 2 && j <= 6));
            tick();
            n_checks++;
            if (o_v !== ev[j]) $display("FAIL overrun_valid j=%0d got %b exp %b", j, o_v, ev[j]); else n_pass++;
            if (ev[j]) begin
                n_checks++;
                if ({o_i, o_idx} !== {10'(mi[eg[j]]), 4'(eg[j])})
                    $display("FAIL overrun_hold j=%0d got i=%0d idx=%0d exp i=%0d idx=%0d",
                             j, $signed(o_i), o_idx, mi[eg[j]], eg[j]);
                else n_pass++;
            end
            n_checks++;
            if (o_ov !== (j >= 3)) $display("FAIL overrun_flag j=%0d got %b exp %b", j, o_ov, (j >= 3)); else n_pass++;
        end
        drive(1'b0, 0, 0, 1'b1);
        tick();
        n_checks++;
        if ({o_v, o_ov} !== 2'b00) $display("FAIL overrun_clear got v/ov=%b exp 00", {o_v, o_ov}); else n_pass++;
    endtask

    task automatic test_en_drop();
        dfac = 3'd3;
        drive(1'b1, 0, 0, 1'b1);
        tick();
        for (int j = 0; j < 8; j++) begin
            drive(j < 5, 400, -400, 1'b1);
            tick();
            n_checks++;
            if (o_v !== 1'b0) $display("FAIL en_drop_partial j=%0d got valid %b exp 0", j, o_v); else n_pass++;
        end
        pat_i.delete(); pat_q.delete();
        for (int k = 0; k < 8; k++) begin
            pat_i.push_back(rnd_s());
            pat_q.push_back(rnd_s());
        end
        run_stream(1, 3, 0, "after_drop_d1");
    endtask

    task automatic test_continuous_and_reset();
        int v[14];
        int y;
        dfac = 3'd0;
        drive(1'b1, 0, 0, 1'b1);
        tick();
        n_checks++;
        if (c_v !== 1'b0) $display("FAIL cont_entry got valid %b exp 0", c_v); else n_pass++;
        for (int k = 0; k < 14; k++) begin
            v[k] = rnd_s();
            drive(1'b1, v[k], -v[k], 1'b1);
            tick();
            n_checks++;
            if ({c_v, c_i, c_q, c_idx, c_last, c_fd} !==
                {1'b1, 10'(v[k]), 10'(-v[k]), 4'(k % 12), (k % 12 == 11), 1'b0})
                $display("FAIL cont_wrap k=%0d got v=%b i=%0d idx=%0d last=%b fd=%b exp i=%0d idx=%0d",
                         k, c_v, $signed(c_i), c_idx, c_last, c_fd, v[k], k % 12);
            else n_pass++;
        end
        rst_n = 1'b0;
        drive(1'b1, 77, 77, 1'b1);
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({c_i, c_q, c_v, c_last, c_idx, c_fd, c_ov} !== 29'd0)
            $display("FAIL reset_mid_cont got %h exp 0", {c_i, c_q, c_v, c_last, c_idx, c_fd, c_ov});
        else n_pass++;
        n_checks++;
        if ({o_i, o_q, o_v, o_last, o_idx, o_fd, o_ov} !== 29'd0)
            $display("FAIL reset_mid_main got %h exp 0", {o_i, o_q, o_v, o_last, o_idx, o_fd, o_ov});
        else n_pass++;
        drive(1'b1, 99, 99, 1'b1);
        tick();
        n_checks++;
        if (c_v !== 1'b0) $display("FAIL reset_idle_entry got valid %b exp 0", c_v); else n_pass++;
        y = rnd_s();
        drive(1'b1, y, 0, 1'b1);
        tick();
        n_checks++;
        if ({c_v, c_i, c_idx} !== {1'b1, 10'(y), 4'd0})
            $display("FAIL reset_restart got v=%b i=%0d idx=%0d exp v=1 i=%0d idx=0", c_v, $signed(c_i), c_idx, y);
        else n_pass++;
        drive(1'b0, 0, 0, 1'b1);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_d2();
        test_floor_and_limits();
        test_random_ratios();
        test_d0_frame();
        test_overrun();
        test_en_drop();
        test_continuous_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
